// File: rtl/hdd_sd_agent.sv
// hdd_sd_agent: SD engine control sequencer and shared-FIFO DMA responder; HDD_SD_AGENT_MUTEX_EN adds the mutex acquire/retry before each command
module hdd_sd_agent #(
  parameter int FIFO_AW = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_sector,
  input  logic [7:0]  req_count,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  sdc_address,
  output logic        sdc_read,
  output logic        sdc_write,
  output logic [31:0] sdc_writedata,
  input  logic [31:0] sdc_readdata,
  input  logic        dma_write,
  input  logic [31:0] dma_writedata,
  input  logic        dma_read,
  output logic [31:0] dma_readdata,
  output logic        dma_readdatavalid,
  output logic        dma_waitrequest,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready
);
  typedef enum logic [2:0] {IDLE, MUTEX, MUTEX_CHK, SECTOR, COUNT, CMD, XFER, DONE} state_t;
`ifdef HDD_SD_AGENT_MUTEX_EN
  localparam state_t FIRST = MUTEX;
`else
  localparam state_t FIRST = SECTOR;
`endif
  state_t state, state_n;
  logic up, wr_mode, pend;
  logic [23:0] sector;
  logic [7:0] count;
  logic [14:0] total, xcnt, pcnt;
  logic [31:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] fcnt;
  logic full, empty, accept, rd_x, wr_x, dma_pop, push, pop;
  assign full = fcnt[FIFO_AW];
  assign empty = fcnt == '0;
  assign accept = req_valid && req_ready;
  assign rd_x = state == XFER && !wr_mode;
  assign wr_x = state == XFER && wr_mode;
  assign dma_pop = wr_x && pend && !empty;
  assign pop = (rd_valid && rd_ready) || dma_pop;
  assign push = (rd_x && dma_write && (!full || pop)) || (wr_valid && wr_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      up <= 1'b0;
      wr_mode <= 1'b0;
      pend <= 1'b0;
      sector <= '0;
      count <= '0;
      total <= '0;
      xcnt <= '0;
      pcnt <= '0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      overflow <= 1'b0;
      dma_readdata <= '0;
      dma_readdatavalid <= 1'b0;
    end else begin
      state <= state_n;
      up <= 1'b1;
      if (accept) begin
        wr_mode <= req_write;
        sector <= req_sector;
        count <= req_count;
        total <= {req_count, 7'b0};
        xcnt <= '0;
        pcnt <= '0;
        overflow <= 1'b0;
      end
      if ((rd_x && dma_write) || dma_pop) xcnt <= xcnt + 15'd1;
      if (wr_valid && wr_ready) pcnt <= pcnt + 15'd1;
      if (rd_x && dma_write && full && !pop) overflow <= 1'b1;
      pend <= wr_x && (dma_read || (pend && empty));
      dma_readdatavalid <= dma_pop;
      if (dma_pop) dma_readdata <= mem[rp];
      if (push) wp <= wp + FIFO_AW'(1);
      if (pop) rp <= rp + FIFO_AW'(1);
      fcnt <= fcnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_mode ? wr_data : dma_writedata;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept) state_n = req_count == 8'd0 ? DONE : FIRST;
      MUTEX:     state_n = MUTEX_CHK;
      MUTEX_CHK: state_n = sdc_readdata == 32'd2 ? SECTOR : MUTEX;
      SECTOR:    state_n = COUNT;
      COUNT:     state_n = CMD;
      CMD:       state_n = XFER;
      XFER:      if (xcnt == total) state_n = DONE;
      DONE:      if (empty) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE && up;
    done = state == DONE && empty;
`ifdef HDD_SD_AGENT_MUTEX_EN
    sdc_read = state == MUTEX;
`else
    sdc_read = 1'b0;
`endif
    sdc_write = state == SECTOR || state == COUNT || state == CMD;
    sdc_address = state == SECTOR ? 2'd1 : (state == MUTEX || state == COUNT) ? 2'd2 : state == CMD ? 2'd3 : 2'd0;
    sdc_writedata = state == SECTOR ? {8'b0, sector} : state == COUNT ? {24'b0, count} :
                    state == CMD ? {30'b0, 1'b1, wr_mode} : 32'd0;
    dma_waitrequest = rd_x && full;
    rd_valid = !wr_mode && !empty;
    rd_data = mem[rp];
    wr_ready = wr_x && !full && pcnt != total;
  end
endmodule

// File: tb/tb_hdd_sd_agent.sv
// tb_hdd_sd_agent: randomized engine/HDD stimulus for hdd_sd_agent checked against a transaction-level reference model
module tb_hdd_sd_agent;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;
`ifdef HDD_SD_AGENT_MUTEX_EN
  localparam bit MTX = 1'b1;
`else
  localparam bit MTX = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [23:0] req_sector = '0;
  logic [7:0] req_count = '0;
  logic req_ready, done, overflow, sdc_read, sdc_write, dma_readdatavalid, dma_waitrequest, rd_valid, wr_ready;
  logic [1:0] sdc_address;
  logic [31:0] sdc_writedata, dma_readdata, rd_data;
  logic [31:0] sdc_readdata = '0, dma_writedata = '0, wr_data = '0;
  logic dma_write = 1'b0, dma_read = 1'b0, rd_ready = 1'b0, wr_valid = 1'b0;
  int n_tests = 0, n_fail = 0;
  int pcyc = 0, ncyc = 0, n_sdc_read = 0, n_done = 0, done_cyc = 0, last_pop = 0, rd_cnt = 0, fail_target = 0;
  logic [33:0] sdc_log [$];
  logic [31:0] rd_log [$];
  logic [31:0] dma_log [$];
  hdd_sd_agent #(.FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sector(req_sector), .req_count(req_count),
    .done(done), .overflow(overflow),
    .sdc_address(sdc_address), .sdc_read(sdc_read), .sdc_write(sdc_write),
    .sdc_writedata(sdc_writedata), .sdc_readdata(sdc_readdata),
    .dma_write(dma_write), .dma_writedata(dma_writedata), .dma_read(dma_read),
    .dma_readdata(dma_readdata), .dma_readdatavalid(dma_readdatavalid), .dma_waitrequest(dma_waitrequest),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pcyc++;
    if (sdc_read) begin
      sdc_readdata <= rd_cnt < fail_target ? 32'd0 : 32'd2;
      rd_cnt++;
    end
  end
  always @(negedge clk) begin
    ncyc++;
    if (sdc_write) sdc_log.push_back({sdc_address, sdc_writedata});
    if (sdc_read) n_sdc_read++;
    if (rd_valid && rd_ready) begin
      rd_log.push_back(rd_data);
      last_pop = ncyc;
    end
    if (dma_readdatavalid) dma_log.push_back(dma_readdata);
    if (done) begin
      n_done++;
      done_cyc = ncyc;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int lat(input int f);
    return MTX ? 4 + 2 * f : 2;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    dma_write = 1'b0;
    dma_read = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 64'({req_ready, done, overflow, sdc_read, sdc_write, sdc_address,
                        dma_readdatavalid, dma_waitrequest, rd_valid, wr_ready}), 64'd0);
    chk("rst_data", {sdc_writedata, dma_readdata}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rst_ready_high", 64'(req_ready), 64'd1);
    chk("rst_fifo_empty", 64'(rd_valid), 64'd0);
  endtask
  task automatic request(input logic w, input int sector, input int cnt, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = w;
    req_sector = 24'(sector);
    req_count = 8'(cnt);
    @(posedge clk);
    #1 req_valid = 1'b0;
    acc = pcyc;
  endtask
  task automatic wait_cmd(input int acc, input int l);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sdc_write && sdc_address == 2'd3) && t < 200);
    chk("cmd_latency", 64'(pcyc - acc), 64'(l));
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input int db);
    int t;
    t = 0;
    while (n_done == db && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(n_done - db), 64'd1);
  endtask
  task automatic check_ctrl(input int sb, input logic w, input int sector, input int cnt);
    logic [33:0] exp [3];
    exp[0] = {2'd1, 8'd0, 24'(sector)};
    exp[1] = {2'd2, 24'd0, 8'(cnt)};
    exp[2] = {2'd3, 30'd0, 1'b1, w};
    chk("sdc_writes", 64'(sdc_log.size() - sb), 64'd3);
    for (int i = 0; i < 3; i++)
      if (sb + i < sdc_log.size()) chk($sformatf("sdc_write%0d", i), 64'(sdc_log[sb + i]), 64'(exp[i]));
  endtask
  task automatic do_read(input int sector, input int cnt, input int mode, input int fails);
    logic [31:0] sent [$];
    int sb, rb, db, r0, acc, n, keep;
    sb = sdc_log.size();
    rb = rd_log.size();
    db = n_done;
    r0 = n_sdc_read;
    fail_target = rd_cnt + fails;
    n = cnt * 128;
    rd_ready = mode == 0;
    request(1'b0, sector, cnt, acc);
    wait_cmd(acc, lat(fails));
    for (int i = 0; i < n; i++) begin
      dma_write = 1'b1;
      dma_writedata = $urandom;
      sent.push_back(dma_writedata);
      if (mode == 2) rd_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    dma_write = 1'b0;
    if (mode == 1 && n >= DEPTH) chk("waitreq_full", 64'(dma_waitrequest), 64'd1);
    rd_ready = 1'b1;
    wait_done(db);
    keep = (mode == 1 && n > DEPTH) ? DEPTH : n;
    chk("rd_words", 64'(rd_log.size() - rb), 64'(keep));
    for (int i = 0; i < keep; i++)
      if (rb + i < rd_log.size()) chk("rd_word", 64'(rd_log[rb + i]), 64'(sent[i]));
    chk("overflow", 64'(overflow), 64'(mode == 1 && n > DEPTH));
    chk("done_after_pop", 64'(done_cyc - last_pop), 64'd1);
    chk("sdc_reads", 64'(n_sdc_read - r0), MTX ? 64'(fails + 1) : 64'd0);
    check_ctrl(sb, 1'b0, sector, cnt);
  endtask
  task automatic do_write(input int sector, input int cnt, input int fails);
    logic [31:0] exp [$];
    int sb, dlb, db, r0, acc, n;
    sb = sdc_log.size();
    dlb = dma_log.size();
    db = n_done;
    r0 = n_sdc_read;
    fail_target = rd_cnt + fails;
    n = cnt * 128;
    request(1'b1, sector, cnt, acc);
    wait_cmd(acc, lat(fails));
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int t;
          t = 0;
          wr_data = $urandom;
          exp.push_back(wr_data);
          wr_valid = 1'b1;
          do begin
            @(negedge clk);
            t++;
          end while (!wr_ready && t < 4000);
          @(posedge clk);
          #1 wr_valid = 1'b0;
          repeat (2) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          int t;
          t = 0;
          dma_read = 1'b1;
          @(posedge clk);
          #1 dma_read = 1'b0;
          do begin
            @(negedge clk);
            t++;
          end while (!dma_readdatavalid && t < 4000);
          @(posedge clk);
          #1;
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
        end
      end
    join
    wait_done(db);
    chk("dma_words", 64'(dma_log.size() - dlb), 64'(n));
    for (int i = 0; i < n; i++)
      if (dlb + i < dma_log.size()) chk("dma_word", 64'(dma_log[dlb + i]), 64'(exp[i]));
    chk("wr_overflow", 64'(overflow), 64'd0);
    chk("sdc_reads", 64'(n_sdc_read - r0), MTX ? 64'(fails + 1) : 64'd0);
    check_ctrl(sb, 1'b1, sector, cnt);
  endtask
  task automatic do_zero(input logic w);
    int sb, rb, dlb, db, r0, acc;
    sb = sdc_log.size();
    rb = rd_log.size();
    dlb = dma_log.size();
    db = n_done;
    r0 = n_sdc_read;
    request(w, int'($urandom_range(0, 24'hFFFFFF)), 0, acc);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    chk("zero_done_n", 64'(n_done - db), 64'd1);
    chk("zero_sdc", 64'(sdc_log.size() - sb + n_sdc_read - r0), 64'd0);
    chk("zero_dma", 64'(dma_log.size() - dlb + rd_log.size() - rb), 64'd0);
  endtask
  initial begin
    int acc;
    do_reset();
    do_read(24'h10, 1, 0, 0);
    do_read(int'($urandom_range(0, 24'hFFFFFF)), 4, 1, 0);
    do_read(int'($urandom_range(0, 24'hFFFFFF)), 5, 1, 0);
    do_write(int'($urandom_range(0, 24'hFFFFFF)), 2, 0);
    do_zero(1'b0);
    do_zero(1'b1);
    do_read(int'($urandom_range(0, 24'hFFFFFF)), 1, 2, 2);
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(1, 2)), int'($urandom_range(0, 1)));
      else
        do_read(int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(1, 3)), 2, int'($urandom_range(0, 1)));
    end
    fail_target = rd_cnt;
    rd_ready = 1'b0;
    request(1'b0, int'($urandom_range(0, 24'hFFFFFF)), 1, acc);
    wait_cmd(acc, lat(0));
    for (int i = 0; i < 60; i++) begin
      dma_write = 1'b1;
      dma_writedata = $urandom;
      @(posedge clk);
      #1;
    end
    do_reset();
    do_read(int'($urandom_range(0, 24'hFFFFFF)), 1, 0, 0);
    if (!MTX) chk("no_sdc_read", 64'(n_sdc_read), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hdd_sd_agent.md
# hdd_sd_agent

Host-side agent for the SD sector engine in the ao486 simulation SoC. It sequences the engine's four-register control port to launch multi-sector transfers. It also acts as the Avalon responder for the engine's streaming data master, buffering sector words in one shared FIFO between that master and the HDD core. One request is in flight at a time, either a read (SD to HDD) or a write (HDD to SD).

## Interface
- `FIFO_AW`, default 9: FIFO depth is 2^FIFO_AW 32-bit words (default 512 words = 4 sectors).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` / `req_ready` in/out 1: request handshake. Accepted when both are high.
- `req_write` in 1: 1 = HDD-to-SD (engine command 3), 0 = SD-to-HDD (command 2).
- `req_sector` in 24: starting LBA.
- `req_count` in 8: sector count.
- `done` out 1: one-cycle pulse when the request completes.
- `overflow` out 1: sticky flag, read-mode word dropped. Cleared when the next request is accepted.
- `sdc_address` out 2: engine control register select.
- `sdc_read` / `sdc_write` out 1: control-port strobes.
- `sdc_writedata` out 32: control-port write data.
- `sdc_readdata` in 32: control-port read data, valid one cycle after `sdc_read`.
- `dma_write` / `dma_writedata` in 1/32: engine pushes a word (read mode).
- `dma_read` in 1: engine requests one word (write mode).
- `dma_readdata` / `dma_readdatavalid` out 32/1: response word.
- `dma_waitrequest` out 1: FIFO full in read mode (advisory; the engine does not honour it).
- `rd_data` / `rd_valid` / `rd_ready` out/out/in: FIFO drain to the HDD core (read mode).
- `wr_data` / `wr_valid` / `wr_ready` in/in/out: FIFO fill from the HDD core (write mode).

## Operation
States: IDLE, MUTEX, MUTEX_CHK, SECTOR, COUNT, CMD, XFER, DONE.
- **IDLE**
  - `req_ready`=1.
  - On accept: latch direction, sector and count; clear `overflow`; set total = count×128 words (15-bit).
  - If count==0: go to DONE with no bus activity.
  - Otherwise: go to MUTEX, or to SECTOR when the mutex feature is compiled out.
- **MUTEX**: `sdc_read`=1, `sdc_address`=2, one cycle.
- **MUTEX_CHK**: sample `sdc_readdata`. Equal to 2 → SECTOR; otherwise → MUTEX (retry, unbounded).
- **SECTOR / COUNT / CMD**: one-cycle `sdc_write` to addresses 1, 2, 3 respectively.
  - Data = {8'b0, sector}, {24'b0, count}, and 2 (read) or 3 (write).
  - Exactly one strobe per cycle, in this order.
- **XFER, read mode**
  - Each `dma_write` pushes `dma_writedata`, or drops it and sets `overflow` if the FIFO is full with no pop that cycle.
  - Dropped words still count toward total.
  - Go to DONE when received==total.
  - Then hold `rd_valid` until the FIFO drains before issuing `done`.
- **XFER, write mode**
  - `wr_ready` = FIFO not full and pushed<total.
  - A `dma_read` is recorded as pending (at most one).
  - Pending and FIFO non-empty → pop; `dma_readdatavalid`=1 with the head word on the next cycle.
  - Go to DONE when delivered==total.
- **DONE**: `done`=1 for one cycle → IDLE.
- A `dma_*` strobe outside XFER of a matching direction is ignored.
- FIFO: pointers wrap modulo 2^FIFO_AW, with a separate count register (FIFO_AW+1 bits).
  - Push and pop in the same cycle while full is legal; the count is unchanged and `overflow` is not set.

## Timing
- Reset values:
  - All strobes, `done`, `overflow`, `rd_valid`, `wr_ready`, `dma_readdatavalid`, `dma_waitrequest` = 0.
  - `sdc_address`=0, `sdc_writedata`=0, `dma_readdata`=0, `req_ready`=0.
  - State = IDLE; `req_ready` rises the cycle after reset is released.
- Reset mid-operation: FIFO flushed, counters cleared, any pending read dropped. The engine must be reset on the same cycle (shared system reset).
- Command latency, accept to CMD strobe:
  - 4 cycles with the mutex feature, if the first check passes.
  - 2 cycles without it.
- The engine may assert `dma_read` on the cycle after the CMD strobe; it must be captured then.
- Write-mode response: `dma_readdatavalid` occurs at least 1 cycle after `dma_read`. A word pushed in the same cycle is not bypassed; it is visible to the pop on the next cycle.
- Read mode: the FIFO accepts one word per cycle, back to back.

## Configuration
- `HDD_SD_AGENT_MUTEX_EN` defined: the MUTEX/MUTEX_CHK acquire-and-retry sequence precedes every command.
- Not defined: those states are removed and IDLE goes directly to SECTOR; `sdc_read` is tied to 0.

## Test plan
- Read, sector=0x10, count=1, `rd_ready`=1: control writes (1,0x10), (2,1), (3,2) → 128 words out in order → `done` one cycle after the last pop, `overflow`=0.
- Read, count=4, `rd_ready`=0 until all words arrive, FIFO_AW=9: 512 words held, `overflow`=0. Repeat with count=5: `overflow`=1, the first 512 words are intact, and `done` still fires.
- Write, count=2, `wr_valid` asserted every third cycle: 256 `dma_readdatavalid` pulses carrying the pushed words in order; `done` after the 256th.
- count=0, either direction: `done` 1 cycle after accept, no `sdc_*` or `dma_*` activity.
- With MUTEX_EN, `sdc_readdata`=0 on the first two checks then 2: three `sdc_read` pulses, then SECTOR. Without MUTEX_EN: no `sdc_read` ever.
- Reset asserted at word 60 of a 1-sector read: all outputs return to reset values, FIFO empty. A new request after reset completes normally.
